// File: rtl/food_point_gen_if.sv
// Handshake bundle between the game FSM, the food-point generator and the snake-body occupancy store.
interface food_point_gen_if #(
    parameter int GRID_W = 64,
    parameter int GRID_H = 48,
    parameter int X_W    = 10,
    parameter int Y_W    = 9
);
    localparam int CXB = $clog2(GRID_W);
    localparam int CYB = $clog2(GRID_H);

    logic           req;
    logic           busy;
    logic           valid;
    logic           exhausted;
    logic [X_W-1:0] randX;
    logic [Y_W-1:0] randY;
    logic           occ_req;
    logic [CXB-1:0] occ_x;
    logic [CYB-1:0] occ_y;
    logic           occ_hit;

    modport master (
        output req, occ_hit,
        input  busy, valid, exhausted, randX, randY, occ_req, occ_x, occ_y
    );

    modport slave (
        input  req, occ_hit,
        output busy, valid, exhausted, randX, randY, occ_req, occ_x, occ_y
    );
endinterface

// File: rtl/food_point_gen.sv
// Food-position generator: draws LFSR cells, rejects margin/occupied ones and
// falls back to the top-left playable cell after MAX_TRIES candidates.
module food_point_gen #(
    parameter int          GRID_W    = 64,
    parameter int          GRID_H    = 48,
    parameter int          CELL      = 10,
    parameter int          MARGIN    = 2,
    parameter int          X_W       = 10,
    parameter int          Y_W       = 9,
    parameter int          MAX_TRIES = 15,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         CXB       = $clog2(GRID_W),
    localparam int         CYB       = $clog2(GRID_H)
) (
    input logic             VGA_clk,
    input logic             reset,
    food_point_gen_if.slave bus
);
    localparam logic [1:0]     S_IDLE   = 2'd0;
    localparam logic [1:0]     S_DRAW   = 2'd1;
    localparam logic [1:0]     S_QUERY  = 2'd2;
    localparam logic [1:0]     S_WAIT   = 2'd3;
    localparam logic [15:0]    SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [X_W-1:0] FALL_X   = X_W'(MARGIN * CELL);
    localparam logic [Y_W-1:0] FALL_Y   = Y_W'(MARGIN * CELL);
    localparam logic [7:0]     LAST_TRY = 8'(MAX_TRIES - 1);

    logic [1:0]     r_state;
    logic [15:0]    r_lfsr;
    logic [7:0]     r_tries;
    logic [CXB-1:0] r_occ_x;
    logic [CYB-1:0] r_occ_y;
    logic [X_W-1:0] r_rand_x;
    logic [Y_W-1:0] r_rand_y;
    logic           r_valid;
    logic           r_exhausted;

    logic [15:0]    w_lfsr_nxt;
    logic [CXB-1:0] w_cx;
    logic [CYB-1:0] w_cy;
    logic           w_in_range;
    logic           w_last;
    logic [X_W-1:0] w_px;
    logic [Y_W-1:0] w_py;
    logic [1:0]     w_state_nxt;
    logic           w_reject;
    logic           w_accept;
    logic           w_fallback;

    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
    assign w_cx       = r_lfsr[CXB-1:0];
    assign w_cy       = r_lfsr[8 +: CYB];
    assign w_in_range = (int'(w_cx) >= MARGIN) && (int'(w_cx) < GRID_W - MARGIN) &&
                        (int'(w_cy) >= MARGIN) && (int'(w_cy) < GRID_H - MARGIN);
    assign w_last     = (r_tries == LAST_TRY);
    // Pixel coordinates come from the registered query cell, which is stable through WAIT.
    assign w_px       = X_W'(int'(r_occ_x) * CELL);
    assign w_py       = Y_W'(int'(r_occ_y) * CELL);
    assign w_fallback = w_reject && w_last;

    // Next-state decode; a rejection on the last try ends the request instead of redrawing.
    always_comb begin
        w_state_nxt = r_state;
        w_reject    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req) w_state_nxt = S_DRAW;
                else         w_state_nxt = S_IDLE;
            end
            S_DRAW: begin
                if (w_in_range) begin
                    w_state_nxt = S_QUERY;
                end else begin
                    w_reject    = 1'b1;
                    w_state_nxt = w_last ? S_IDLE : S_DRAW;
                end
            end
            S_QUERY: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.occ_hit) begin
                    w_reject    = 1'b1;
                    w_state_nxt = w_last ? S_IDLE : S_DRAW;
                end else begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, LFSR, try counter, query cell and result registers.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lfsr      <= SEED_EFF;
            r_tries     <= 8'd0;
            r_occ_x     <= '0;
            r_occ_y     <= '0;
            r_rand_x    <= FALL_X;
            r_rand_y    <= FALL_Y;
            r_valid     <= 1'b0;
            r_exhausted <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_valid <= w_accept | w_fallback;
            if (r_state == S_IDLE && bus.req) r_tries <= 8'd0;
            else if (w_reject && !w_last)     r_tries <= r_tries + 8'd1;
            else                              r_tries <= r_tries;
            if (r_state == S_DRAW && w_in_range) begin
                r_occ_x <= w_cx;
                r_occ_y <= w_cy;
            end
            if (w_accept) begin
                r_rand_x    <= w_px;
                r_rand_y    <= w_py;
                r_exhausted <= 1'b0;
            end else if (w_fallback) begin
                r_rand_x    <= FALL_X;
                r_rand_y    <= FALL_Y;
                r_exhausted <= 1'b1;
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.occ_req   = (r_state == S_QUERY);
    assign bus.occ_x     = r_occ_x;
    assign bus.occ_y     = r_occ_y;
    assign bus.valid     = r_valid;
    assign bus.exhausted = r_exhausted;
    assign bus.randX     = r_rand_x;
    assign bus.randY     = r_rand_y;
endmodule

// File: tb/tb_food_point_gen.sv
// Randomised directed bench for food_point_gen against a candidate-walk reference model.
module tb_food_point_gen;
    localparam int GRID_W = 64, GRID_H = 48, CELL = 10, MARGIN = 2, MAX_TRIES = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   q_total = 0;
    int   q_base = 0;
    int   hit_limit = 0;
    logic [15:0] m_lfsr = 16'h0001;
    int   prev_x = 20, prev_y = 20, prev_ex = 0;

    food_point_gen_if #(.GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(10), .Y_W(9)) bus ();

    food_point_gen #(.SEED(16'h0000)) dut (
        .VGA_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[14] ^ l[12] ^ l[3]};
    endfunction

    // Walks candidates: range miss costs 1 cycle, occupancy hit 3; lat = edges from req edge to valid.
    function automatic void model(input logic [15:0] l0, input int hits, output int lat,
                                  output int ex, output int px, output int py, output int nq);
        logic [15:0] l;
        int t, cx, cy;
        l = l0; t = 0; nq = 0; ex = 1; px = MARGIN * CELL; py = MARGIN * CELL;
        for (int i = 0; i < MAX_TRIES; i++) begin
            cx = int'(l[5:0]);
            cy = int'(l[13:8]);
            if (cx >= MARGIN && cx < GRID_W - MARGIN && cy >= MARGIN && cy < GRID_H - MARGIN) begin
                nq++;
                t += 3;
                if (nq > hits) begin
                    lat = t; ex = 0; px = cx * CELL; py = cy * CELL;
                    return;
                end
                for (int k = 0; k < 3; k++) l = lfsr_next(l);
            end else begin
                t += 1;
                l = lfsr_next(l);
            end
        end
        lat = t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'h0001;
        else     m_lfsr <= lfsr_next(m_lfsr);
    end

    // Occupancy store model: answers the first hit_limit queries of a request with a hit.
    always @(posedge clk) begin
        if (rst) bus.occ_hit <= 1'b0;
        else     bus.occ_hit <= bus.occ_req && ((q_total - q_base) < hit_limit);
        q_total <= q_total + (bus.occ_req ? 1 : 0);
    end

    task automatic do_req(input int hits, input bit keep_req);
        int lat, ex, px, py, nq, n;
        logic [15:0] l0;
        bit busy_ok;
        q_base = q_total;
        hit_limit = hits;
        bus.req = 1'b1;
        @(posedge clk); #1;
        if (!keep_req) bus.req = 1'b0;
        l0 = m_lfsr;
        model(l0, hits, lat, ex, px, py, nq);
        chk("busy_after_req", 32'(bus.busy), 32'd1);
        chk("hold_x", 32'(bus.randX), 32'(prev_x));
        chk("hold_exh", 32'(bus.exhausted), 32'(prev_ex));
        busy_ok = 1'b1;
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            n = c;
            if (bus.valid) break;
            if (!bus.busy) busy_ok = 1'b0;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("busy_while_running", 32'(busy_ok), 32'd1);
        chk("busy_in_valid", 32'(bus.busy), 32'd0);
        chk("randX", 32'(bus.randX), 32'(px));
        chk("randY", 32'(bus.randY), 32'(py));
        chk("exhausted", 32'(bus.exhausted), 32'(ex));
        chk("queries", 32'(q_total - q_base), 32'(nq));
        prev_x = px; prev_y = py; prev_ex = ex;
    endtask

    initial begin
        bit no_valid, saw_q;
        bus.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lfsr", 32'(dut.r_lfsr), 32'h0001);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_exh", 32'(bus.exhausted), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_occ_req", 32'(bus.occ_req), 32'd0);
        chk("rst_occ_xy", 32'({bus.occ_x, bus.occ_y}), 32'd0);
        chk("rst_randX", 32'(bus.randX), 32'd20);
        chk("rst_randY", 32'(bus.randY), 32'd20);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("lfsr_4cyc", 32'(dut.r_lfsr), 32'h0011);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            do_req(0, 1'b0);
            chk("range_mult", 32'(bus.randX >= 20 && bus.randX <= 610 && bus.randY >= 20 &&
                                  bus.randY <= 450 && bus.randX % 10 == 0 && bus.randY % 10 == 0), 32'd1);
        end

        do_req(1000, 1'b0);
        chk("all_hit_exh", 32'(bus.exhausted), 32'd1);
        chk("all_hit_x", 32'(bus.randX), 32'd20);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            do_req(2, 1'b0);
        end

        for (int i = 0; i < 30; i++) do_req($urandom_range(0, 1), 1'b1);
        bus.req = 1'b0;
        @(posedge clk); #1;
        chk("held_release_idle", 32'(bus.busy), 32'd0);

        q_base = q_total;
        hit_limit = 1000;
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        saw_q = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus.occ_req) begin
                saw_q = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("wait_query_seen", 32'(saw_q), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_valid", 32'(bus.valid), 32'd0);
        chk("abort_lfsr", 32'(dut.r_lfsr), 32'h0001);
        rst = 1'b0;
        no_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.valid || bus.busy) no_valid = 1'b0;
        end
        chk("abort_no_valid", 32'(no_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
